// File: rtl/fsm_pkg.sv
// Shared definitions for the pattern sequencer and its FSM: sequencer states,
// FSM output bit positions and codes, and pattern entry field layout.
package fsm_pkg;

    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StReset = 3'd1,
        StRun   = 3'd2,
        StDrain = 3'd3,
        StDone  = 3'd4
    } seq_state_e;

    // FSM output vector {o3,u8,U6,U9}
    localparam int unsigned OUT_W = 4;
    localparam int unsigned O3    = 3;
    localparam int unsigned U8    = 2;
    localparam int unsigned U6    = 1;
    localparam int unsigned U9    = 0;

    // Pattern entry layout: {a2, i2, expected outputs}
    localparam int unsigned ENTRY_W = 6;
    localparam int unsigned A2_B    = 5;
    localparam int unsigned I2_B    = 4;
    localparam int unsigned EXP_HI  = 3;
    localparam int unsigned EXP_LO  = 0;

    // Moore output codes of the FSM states
    localparam logic [OUT_W-1:0] OUT_C1 = 4'b1000;
    localparam logic [OUT_W-1:0] OUT_N7 = 4'b0000;
    localparam logic [OUT_W-1:0] OUT_C2 = 4'b1111;
    localparam logic [OUT_W-1:0] OUT_G1 = 4'b0110;
    localparam logic [OUT_W-1:0] OUT_E0 = 4'b0011;

endpackage

// File: rtl/fsm_seq_mem.sv
// Pattern register file: synchronous write, asynchronous read, no reset so
// contents survive a sequencer reset.
module fsm_seq_mem
    import fsm_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk_i,
    input  logic               we_i,
    input  logic [ADDR_W-1:0]  waddr_i,
    input  logic [ENTRY_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0]  raddr_i,
    output logic [ENTRY_W-1:0] rdata_o
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;

    logic [ENTRY_W-1:0] mem_q [DEPTH];

    // Write port
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/fsm_seq_ctrl.sv
// Pattern sequencer/checker: resets the FSM, steps it one stored vector per
// clock and counts output mismatches one cycle after each vector is applied.
module fsm_seq_ctrl
    import fsm_pkg::*;
#(
    parameter int unsigned ADDR_W = 4
) (
    input  logic               clk_i,
    input  logic               rst_i,
    input  logic               wr_en_i,
    input  logic [ADDR_W-1:0]  wr_addr_i,
    input  logic [ENTRY_W-1:0] wr_data_i,
    input  logic [ADDR_W:0]    len_i,
    input  logic               start_i,
    output logic               busy_o,
    output logic               done_o,
    output logic               pass_o,
    output logic [ADDR_W:0]    err_cnt_o,
    output logic [ADDR_W-1:0]  first_err_idx_o,
    output logic               fsm_rst_o,
    output logic               fsm_a2_o,
    output logic               fsm_i2_o,
    input  logic [OUT_W-1:0]   fsm_out_i
);
    localparam int unsigned DEPTH = 2 ** ADDR_W;
    localparam int unsigned LenW  = ADDR_W + 1;

    seq_state_e         state_q, state_d;
    logic [ADDR_W-1:0]  idx_q, idx_d;
    logic [LenW-1:0]    eff_len_q, eff_len_d;
    logic [OUT_W-1:0]   exp_q, exp_d;
    logic [ADDR_W-1:0]  cmp_idx_q, cmp_idx_d;
    logic               cmp_vld_q, cmp_vld_d;
    logic [LenW-1:0]    err_cnt_q, err_cnt_d;
    logic [ADDR_W-1:0]  first_err_q, first_err_d;
    logic               pass_q, pass_d;

    logic [ENTRY_W-1:0] rd_entry;
    logic [LenW-1:0]    len_clamped;
    logic               last_step;
    logic               mismatch;

    fsm_seq_mem #(
        .ADDR_W (ADDR_W)
    ) u_mem (
        .clk_i   (clk_i),
        .we_i    (wr_en_i && (state_q == StIdle)),
        .waddr_i (wr_addr_i),
        .wdata_i (wr_data_i),
        .raddr_i (idx_q),
        .rdata_o (rd_entry)
    );

    assign len_clamped = (len_i > LenW'(DEPTH)) ? LenW'(DEPTH) : len_i;
    assign last_step   = ({1'b0, idx_q} == (eff_len_q - LenW'(1)));
    assign mismatch    = cmp_vld_q && (fsm_out_i != exp_q);

    // State register
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (start_i) state_d = (len_clamped == '0) ? StDone : StReset;
            StReset: state_d = StRun;
            StRun:   if (last_step) state_d = StDrain;
            StDrain: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Moore outputs and FSM drive
    always_comb begin
        busy_o   = 1'b0;
        done_o   = 1'b0;
        fsm_a2_o = 1'b0;
        fsm_i2_o = 1'b0;
        unique case (state_q)
            StReset, StDrain: busy_o = 1'b1;
            StRun: begin
                busy_o   = 1'b1;
                fsm_a2_o = rd_entry[A2_B];
                fsm_i2_o = rd_entry[I2_B];
            end
            StDone:  done_o = 1'b1;
            default: ;
        endcase
    end

    assign fsm_rst_o = rst_i | (state_q == StReset);

    // Datapath next state: stepping index, pending compare and result tally
    always_comb begin
        idx_d       = idx_q;
        eff_len_d   = eff_len_q;
        exp_d       = exp_q;
        cmp_idx_d   = cmp_idx_q;
        cmp_vld_d   = 1'b0;
        err_cnt_d   = err_cnt_q;
        first_err_d = first_err_q;
        pass_d      = pass_q;

        if (mismatch) begin
            err_cnt_d = err_cnt_q + LenW'(1);
            if (err_cnt_q == '0) begin
                first_err_d = cmp_idx_q;
            end
        end

        unique case (state_q)
            StIdle: begin
                if (start_i) begin
                    eff_len_d   = len_clamped;
                    idx_d       = '0;
                    err_cnt_d   = '0;
                    first_err_d = '0;
                    // A zero-length run goes straight to DONE and passes trivially
                    pass_d      = (len_clamped == '0);
                end
            end
            StRun: begin
                exp_d     = rd_entry[EXP_HI:EXP_LO];
                cmp_idx_d = idx_q;
                cmp_vld_d = 1'b1;
                idx_d     = idx_q + ADDR_W'(1);
            end
            // Last compare lands on the edge into DONE, so use its result here
            StDrain: pass_d = (err_cnt_d == '0);
            default: ;
        endcase
    end

    // Datapath registers
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            idx_q       <= '0;
            eff_len_q   <= '0;
            exp_q       <= '0;
            cmp_idx_q   <= '0;
            cmp_vld_q   <= 1'b0;
            err_cnt_q   <= '0;
            first_err_q <= '0;
            pass_q      <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            eff_len_q   <= eff_len_d;
            exp_q       <= exp_d;
            cmp_idx_q   <= cmp_idx_d;
            cmp_vld_q   <= cmp_vld_d;
            err_cnt_q   <= err_cnt_d;
            first_err_q <= first_err_d;
            pass_q      <= pass_d;
        end
    end

    assign pass_o          = pass_q;
    assign err_cnt_o       = err_cnt_q;
    assign first_err_idx_o = first_err_q;

endmodule

// File: tb/tb_fsm_seq_ctrl.sv
// Bench for fsm_seq_ctrl: a stand-in FSM answers the sequencer, a run-level
// model predicts each run's outcome into a scoreboard, and a monitor checks
// every done pulse against it.
module tb_fsm_seq_ctrl;
    import fsm_pkg::*;

    logic       clk;
    logic       rst;
    logic       wr_en;
    logic [3:0] wr_addr;
    logic [5:0] wr_data;
    logic [4:0] len;
    logic       start;
    logic       busy;
    logic       done;
    logic       pass;
    logic [4:0] err_cnt;
    logic [3:0] first_err_idx;
    logic       fsm_rst;
    logic       fsm_a2;
    logic       fsm_i2;
    logic [3:0] fsm_out;

    fsm_seq_ctrl #(
        .ADDR_W (4)
    ) dut (
        .clk_i           (clk),
        .rst_i           (rst),
        .wr_en_i         (wr_en),
        .wr_addr_i       (wr_addr),
        .wr_data_i       (wr_data),
        .len_i           (len),
        .start_i         (start),
        .busy_o          (busy),
        .done_o          (done),
        .pass_o          (pass),
        .err_cnt_o       (err_cnt),
        .first_err_idx_o (first_err_idx),
        .fsm_rst_o       (fsm_rst),
        .fsm_a2_o        (fsm_a2),
        .fsm_i2_o        (fsm_i2),
        .fsm_out_i       (fsm_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Stand-in FSM behaviour (resets to N7, E0 absorbs)
    function automatic logic [3:0] sfsm_next(logic [3:0] s, logic a2, logic i2);
        if (s == OUT_E0) return OUT_E0;
        case ({a2, i2})
            2'b11:   return OUT_C2;
            2'b10:   return OUT_E0;
            2'b01:   return (s == OUT_C2 || s == OUT_G1) ? OUT_G1 : OUT_C1;
            default: return s;
        endcase
    endfunction

    logic [3:0] sfsm_q;
    always @(posedge clk) begin
        if (fsm_rst) sfsm_q <= OUT_N7;
        else         sfsm_q <= sfsm_next(sfsm_q, fsm_a2, fsm_i2);
    end
    assign fsm_out = sfsm_q;

    typedef struct {
        int done_cyc;
        int pass;
        int err;
        int fidx;
        int busy_cyc;
        int rst_cyc;
    } exp_t;

    exp_t       sb[$];
    logic [5:0] tb_mem [16];
    int         errors = 0;
    int         checks = 0;
    int         t0 = 0;
    int         busy_cnt = 0;
    int         rst_cnt = 0;
    int         rst_at = -1;
    logic       prev_done = 1'b0;

    task automatic chk(string name, int act, int expv);
        checks++;
        if (act != expv) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, expv, $time);
        end
    endtask

    // Run-level reference: walk the stored vectors through the FSM behaviour
    function automatic exp_t model(int l);
        exp_t       e;
        logic [3:0] s;
        int         eff;
        eff    = (l > 16) ? 16 : l;
        s      = OUT_N7;
        e.err  = 0;
        e.fidx = 0;
        for (int k = 0; k < eff; k++) begin
            s = sfsm_next(s, tb_mem[k][5], tb_mem[k][4]);
            if (s != tb_mem[k][3:0]) begin
                if (e.err == 0) e.fidx = k;
                e.err++;
            end
        end
        e.pass     = (e.err == 0) ? 1 : 0;
        e.done_cyc = (eff == 0) ? 1 : eff + 3;
        e.busy_cyc = (eff == 0) ? 0 : eff + 2;
        e.rst_cyc  = (eff == 0) ? 0 : 1;
        return e;
    endfunction

    // Monitor: cycle n of a run is the period after edge n-1 from start sampling
    always @(negedge clk) begin
        exp_t e;
        if (prev_done) chk("done_pulse_width", int'(done), 0);
        prev_done = done;
        if (busy) busy_cnt++;
        if (fsm_rst) begin
            rst_cnt++;
            if (rst_at < 0) rst_at = cyc - t0;
        end
        if (done) begin
            if (sb.size() == 0) begin
                chk("spurious_done", int'(done), 0);
            end else begin
                e = sb.pop_front();
                chk("done_cycle", cyc - t0, e.done_cyc);
                chk("pass", int'(pass), e.pass);
                chk("err_cnt", int'(err_cnt), e.err);
                if (e.err != 0) chk("first_err_idx", int'(first_err_idx), e.fidx);
                chk("busy_cycles", busy_cnt, e.busy_cyc);
                chk("fsm_rst_cycles", rst_cnt, e.rst_cyc);
                if (e.rst_cyc != 0) chk("fsm_rst_at_cycle", rst_at, 1);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic write_entry(int a, logic [5:0] d);
        wr_en   = 1'b1;
        wr_addr = 4'(a);
        wr_data = d;
        tick();
        wr_en   = 1'b0;
        tb_mem[a] = d;
    endtask

    task automatic launch(int l, bit expect_done);
        if (expect_done) sb.push_back(model(l));
        start = 1'b1;
        len   = 5'(l);
        tick();
        start    = 1'b0;
        t0       = cyc - 1;
        busy_cnt = 0;
        rst_cnt  = 0;
        rst_at   = -1;
    endtask

    task automatic wait_done();
        for (int i = 0; i < 60 && sb.size() != 0; i++) tick();
        chk("run_timeout", sb.size(), 0);
        sb.delete();
    endtask

    task automatic load_basic();
        write_entry(0, 6'b01_1000);
        write_entry(1, 6'b11_1111);
        write_entry(2, 6'b01_0110);
    endtask

    // Random vectors; expected field follows the FSM, occasionally corrupted
    task automatic load_random(int n);
        logic [3:0] s;
        logic [1:0] in;
        logic [3:0] ex;
        s = OUT_N7;
        for (int k = 0; k < n; k++) begin
            in = 2'($urandom_range(0, 3));
            s  = sfsm_next(s, in[1], in[0]);
            ex = s;
            if ($urandom_range(0, 4) == 0) ex = s ^ 4'($urandom_range(1, 15));
            write_entry(k, {in, ex});
        end
    endtask

    initial begin
        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; len = '0; start = 1'b0;
        tick(); tick();
        @(negedge clk);
        chk("reset_busy", int'(busy), 0);
        chk("reset_done", int'(done), 0);
        chk("reset_pass", int'(pass), 0);
        chk("reset_err_cnt", int'(err_cnt), 0);
        chk("reset_fsm_rst", int'(fsm_rst), 1);
        tick();
        rst = 1'b0;
        tick();

        // Basic pass
        load_basic();
        launch(3, 1'b1);
        wait_done();

        // Single mismatch at entry 1
        write_entry(1, 6'b11_0000);
        launch(3, 1'b1);
        wait_done();
        write_entry(1, 6'b11_1111);

        // Full length, clamp, zero length
        write_entry(0, 6'b11_1111);
        for (int k = 1; k < 16; k++) write_entry(k, 6'b10_0011);
        launch(16, 1'b1);
        wait_done();
        launch(20, 1'b1);
        wait_done();
        launch(0, 1'b1);
        wait_done();

        // Reset mid-run at idx=5 (cycle 7), held across two edges
        load_basic();
        launch(16, 1'b0);
        for (int i = 0; i < 6; i++) tick();
        rst = 1'b1;
        @(negedge clk);
        chk("midrst_fsm_rst_c7", int'(fsm_rst), 1);
        tick();
        @(negedge clk);
        chk("midrst_busy", int'(busy), 0);
        chk("midrst_err_cnt", int'(err_cnt), 0);
        chk("midrst_fsm_rst_c8", int'(fsm_rst), 1);
        chk("midrst_fsm_in", int'({fsm_a2, fsm_i2}), 0);
        chk("midrst_pass", int'(pass), 0);
        tick();
        @(negedge clk);
        chk("midrst_fsm_rst_c9", int'(fsm_rst), 1);
        chk("midrst_busy_c9", int'(busy), 0);
        tick();
        rst = 1'b0;
        tick();
        @(negedge clk);
        chk("postrst_fsm_rst", int'(fsm_rst), 0);
        tick();
        launch(3, 1'b1);
        wait_done();

        // Start and write while busy must be ignored
        load_random(8);
        launch(8, 1'b1);
        tick(); tick();
        start   = 1'b1;
        len     = 5'd2;
        wr_en   = 1'b1;
        wr_addr = 4'd7;
        wr_data = tb_mem[7] ^ 6'b00_1111;
        tick();
        start = 1'b0;
        wr_en = 1'b0;
        wait_done();
        launch(8, 1'b1);
        wait_done();

        // Randomised runs
        for (int r = 0; r < 8; r++) begin
            load_random(16);
            launch(int'($urandom_range(0, 20)), 1'b1);
            wait_done();
        end

        tick(); tick();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
